shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter STEP, default 1, giving the maximum bits shifted per cycle in iterative mode; legal values are 1, 2 and 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a shift request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the sequencer accepts a request this cycle.
REQ-006 The block SHALL have port req_a, input, 32 bits: the operand.
REQ-007 The block SHALL have port req_shamt, input, 5 bits: the shift amount.
REQ-008 The block SHALL have port req_type, input, 2 bits: 00=SLL, 01=SRL, 10=SRA, 11=reserved.
REQ-009 The block SHALL have port flush, input, 1 bit: synchronous abort of any operation.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: resp_r holds a completed result.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port resp_r, output, 32 bits: the shift result.
REQ-013 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-015 req_ready SHALL equal (state==IDLE && !flush); a request is accepted on an edge where req_valid && req_ready.
REQ-016 On accept, the block SHALL latch req_a into accumulator acc, latch the type, and set remaining rem=req_shamt.
REQ-017 On accept with req_shamt==0 or req_type==11, the next state SHALL be DONE with resp_r=req_a, giving a latency of 1 cycle.
REQ-018 On accept otherwise, the next state SHALL be SHIFT.
REQ-019 In SHIFT, each cycle SHALL shift acc by k=min(STEP,rem) and set rem=rem-k; when rem reaches 0, the next state SHALL be DONE.
REQ-020 Accept-to-resp_valid latency SHALL be 1+ceil(shamt/STEP) cycles.
REQ-021 SLL and SRL SHALL zero-fill; SRA SHALL fill with bit 31 of the original operand at every step.
REQ-022 In DONE, resp_valid SHALL be 1 and resp_r SHALL be held stable.
REQ-023 In DONE, the block SHALL go to IDLE on the edge where resp_ready=1; resp_valid is 0 the following cycle.
REQ-024 req_ready SHALL be 0 in SHIFT and DONE; requests presented then are ignored and not queued.
REQ-025 flush SHALL force IDLE on the next edge from any state, deassert resp_valid, and discard the result.
REQ-026 flush SHALL take priority over accept and over resp_ready in the same cycle.
REQ-027 resp_r SHALL retain its last value in IDLE; only resp_valid qualifies it.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, resp_valid=0, resp_r=0, acc=0, rem=0 and busy=0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation; no resp_valid is produced after reset releases.
REQ-030 req_ready SHALL be 1 on the first cycle after rst_n rises, provided flush=0.

Configuration
REQ-031 With macro SHIFT_FASTPATH_EN defined, every accepted request SHALL go directly to DONE with the full single-cycle barrel result, giving a latency of 1 for all shamt; SHIFT is never entered and STEP is ignored.
REQ-032 Without SHIFT_FASTPATH_EN, the iterative behaviour of REQ-016 to REQ-021 SHALL apply.

Verification
REQ-033 SLL, a=0x00000001, shamt=31, STEP=1 -> resp_r=0x80000000, resp_valid 32 cycles after accept.
REQ-034 SRA, a=0x80000000, shamt=4 -> resp_r=0xF8000000 at latency 5; SRL with the same inputs -> resp_r=0x08000000.
REQ-035 shamt=0, a=0x12345678 (also type=11, shamt=9) -> resp_r=0x12345678 at latency 1.
REQ-036 Hold resp_ready=0 for 3 cycles in DONE while req_valid=1 -> resp_valid and resp_r stable, req_ready=0, and IDLE one cycle after resp_ready=1.
REQ-037 flush on cycle 2 of a shamt=10 SLL -> IDLE next cycle with no resp_valid; rst_n low mid-SHIFT -> all outputs 0 immediately.
REQ-038 STEP=4, shamt=7 -> two SHIFT cycles (4 then 3) with latency 3; with SHIFT_FASTPATH_EN -> latency 1 and an identical result.

Source files
------------

// File: rtl/shift_sequencer.sv
// Iterative 32-bit shifter (SLL/SRL/SRA) with valid/ready handshake and flush.
// Define SHIFT_FASTPATH_EN to replace the iterative loop with a single-cycle barrel shift.
module shift_sequencer #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [4:0]  req_shamt,
    input  logic [1:0]  req_type,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_r,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] acc;
    logic [4:0]  rem;
    logic [1:0]  typ;
    logic        sgn;
    logic        accept;
    logic        direct;
    logic [4:0]  k;
    logic [31:0] acc_step;
    logic [31:0] direct_r;

    // SRA fills from the operand's original sign bit, carried separately in sgn.
    function automatic logic [31:0] shift_by(input logic [31:0] a, input logic [1:0] t,
                                             input logic fill, input logic [4:0] n);
        logic signed [32:0] ext;
        ext = {fill, a};
        case (t)
            2'b00:   shift_by = a << n;
            2'b01:   shift_by = a >> n;
            2'b10:   begin ext = ext >>> n; shift_by = ext[31:0]; end
            default: shift_by = a;
        endcase
    endfunction

    assign accept   = req_valid && req_ready;
    assign k        = (rem < 5'(STEP)) ? rem : 5'(STEP);
    assign acc_step = shift_by(acc, typ, sgn, k);

`ifdef SHIFT_FASTPATH_EN
    assign direct   = 1'b1;
    assign direct_r = shift_by(req_a, req_type, req_a[31], req_shamt);
`else
    assign direct   = (req_shamt == 5'd0) || (req_type == 2'b11);
    assign direct_r = req_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = direct ? DONE : SHIFT;
            SHIFT:   if (flush) state_nxt = IDLE;
                     else if (rem == k) state_nxt = DONE;
            DONE:    if (flush || resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) && !flush;
        resp_valid = (state == DONE);
        busy       = (state != IDLE);
    end

    // resp_r only moves when a result completes, so it holds through IDLE and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            rem    <= '0;
            typ    <= '0;
            sgn    <= 1'b0;
            resp_r <= '0;
        end else if (accept) begin
            acc <= req_a;
            rem <= req_shamt;
            typ <= req_type;
            sgn <= req_a[31];
            if (direct) resp_r <= direct_r;
        end else if (state == SHIFT && !flush) begin
            acc <= acc_step;
            rem <= rem - k;
            if (rem == k) resp_r <= acc_step;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: a STEP=1 and a STEP=4 sequencer driven by the same stimulus.
module tb_shift_sequencer;

`ifdef SHIFT_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] r;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_a = '0;
    logic [4:0]  req_shamt = '0;
    logic [1:0]  req_type = '0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b1;
    logic        rdy1, vld1, busy1, rdy4, vld4, busy4;
    logic [31:0] r1, r4;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc1 = 0;
    int   acc4 = 0;
    logic pv1 = 1'b0;
    logic pv4 = 1'b0;
    exp_t q1[$];
    exp_t q4[$];

    shift_sequencer #(.STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
        .req_a(req_a), .req_shamt(req_shamt), .req_type(req_type), .flush(flush),
        .resp_valid(vld1), .resp_ready(resp_ready), .resp_r(r1), .busy(busy1)
    );

    shift_sequencer #(.STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy4),
        .req_a(req_a), .req_shamt(req_shamt), .req_type(req_type), .flush(flush),
        .resp_valid(vld4), .resp_ready(resp_ready), .resp_r(r4), .busy(busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitors: on each rising resp_valid, pop and compare result and latency.
    always @(negedge clk) begin
        if (req_valid && rdy1 && rst_n) acc1 <= cyc;
        if (vld1 && !pv1) begin
            if (q1.size() == 0) fail_now("s1_unexpected_resp");
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("s1_resp_r", r1, e.r);
                chk("s1_latency", 32'(cyc - acc1), 32'(e.lat));
            end
        end
        pv1 <= vld1;
    end

    always @(negedge clk) begin
        if (req_valid && rdy4 && rst_n) acc4 <= cyc;
        if (vld4 && !pv4) begin
            if (q4.size() == 0) fail_now("s4_unexpected_resp");
            else begin
                exp_t e;
                e = q4.pop_front();
                chk("s4_resp_r", r4, e.r);
                chk("s4_latency", 32'(cyc - acc4), 32'(e.lat));
            end
        end
        pv4 <= vld4;
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy1 || busy4) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) fail_now("wait_idle_timeout");
    endtask

    task automatic issue(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] t,
                         input logic [31:0] r, input int l1, input int l4, input bit push);
        exp_t e;
        wait_idle();
        req_a = a; req_shamt = sh; req_type = t; req_valid = 1'b1;
        if (push) begin
            e.r = r;
            e.lat = FAST ? 1 : l1;
            q1.push_back(e);
            e.lat = FAST ? 1 : l4;
            q4.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Directed vectors: operand, shamt, type, expected result, latency STEP=1, STEP=4.
    logic [31:0] va[8]  = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h12345678,
                            32'h12345678, 32'h0000000F, 32'h800000F0, 32'hFFFFFFFF};
    logic [4:0]  vs[8]  = '{5'd31, 5'd4, 5'd4, 5'd0, 5'd9, 5'd7, 5'd7, 5'd31};
    logic [1:0]  vt[8]  = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
    logic [31:0] vr[8]  = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'h12345678,
                            32'h12345678, 32'h00000780, 32'hFF000001, 32'h00000001};
    int          vl1[8] = '{32, 5, 5, 1, 1, 8, 8, 32};
    int          vl4[8] = '{9, 2, 2, 1, 1, 3, 3, 9};

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_resp_valid", {31'd0, vld1}, 32'd0);
        chk("rst_resp_r", r1, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, rdy1}, 32'd1);

        for (int i = 0; i < 8; i++)
            issue(va[i], vs[i], vt[i], vr[i], vl1[i], vl4[i], 1'b1);
        wait_idle();

        // Hold in DONE with a competing request present.
        resp_ready = 1'b0;
        issue(32'h00000003, 5'd2, 2'b00, 32'h0000000C, 3, 2, 1'b1);
        for (int n = 0; n < 20 && !vld1; n++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1;
        req_a = 32'hDEADBEEF;
        req_shamt = 5'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, vld1}, 32'd1);
            chk("hold_resp_r", r1, 32'h0000000C);
            chk("hold_ready", {31'd0, rdy1}, 32'd0);
            chk("hold_valid_s4", {31'd0, vld4}, 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("release_busy", {31'd0, busy1}, 32'd0);
        chk("release_valid", {31'd0, vld1}, 32'd0);
        chk("release_resp_r_kept", r1, 32'h0000000C);

        // Flush on the second cycle of a shamt=10 SLL.
        issue(32'h00000001, 5'd10, 2'b00, 32'h00000400, 1, 1, FAST);
        @(posedge clk); #1;
        flush = 1'b1;
        chk("flush_ready", {31'd0, rdy1}, 32'd0);
        @(posedge clk); #1;
        chk("flush_busy", {31'd0, busy1}, 32'd0);
        chk("flush_valid", {31'd0, vld1}, 32'd0);
        chk("flush_busy_s4", {31'd0, busy4}, 32'd0);
        chk("flush_idle_ready", {31'd0, rdy1}, 32'd0);
        flush = 1'b0;
        #1;
        chk("unflush_ready", {31'd0, rdy1}, 32'd1);
        repeat (12) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of SHIFT.
        issue(32'h00000001, 5'd20, 2'b00, 32'h00100000, 1, 1, FAST);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy1}, 32'd0);
        chk("async_rst_valid", {31'd0, vld1}, 32'd0);
        chk("async_rst_resp_r", r1, 32'd0);
        chk("async_rst_busy_s4", {31'd0, busy4}, 32'd0);
        chk("async_rst_resp_r_s4", r4, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst2", {31'd0, rdy1}, 32'd1);
        repeat (30) @(posedge clk);
        #1;

        chk("scoreboard_empty_s1", 32'(q1.size()), 32'd0);
        chk("scoreboard_empty_s4", 32'(q4.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
